// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared fetch-state encoding, exception codes and address defaults
package mips_defs_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [4:0]  EXC_ADEL       = 5'd4;
    localparam logic [31:0] NOP            = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_TOP     = 32'h0000_6FFC;

endpackage

// File: rtl/pc_addr_check.sv
// rtl/pc_addr_check.sv - flags a fetch address error for misaligned or out-of-range PCs
module pc_addr_check (
    input  logic [31:0] pc_i,
    input  logic [31:0] im_base_i,
    input  logic [31:0] im_top_i,
    output logic        adel_o
);

    assign adel_o = (pc_i[1:0] != 2'b00) || (pc_i < im_base_i) || (pc_i > im_top_i);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC, one-outstanding instruction fetch and CP0 redirects
// Optional PC_FETCH_PERF_EN adds fetch and stall event counters.
module pc_fetch_unit
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter logic [31:0] IM_BASE    = DEF_IM_BASE,
    parameter logic [31:0] IM_TOP     = DEF_IM_TOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc_i,
    input  logic        stall_i,
    input  logic        exc_req_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic [31:0] pc_o,
    output logic        im_req_o,
    output logic [31:0] im_addr_o,
    input  logic        im_gnt_i,
    input  logic        im_rvalid_i,
    input  logic [31:0] im_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        if_exc_o,
    output logic [4:0]  if_exccode_o
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic         adel_q, adel_d;
    logic         drop_q, drop_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         if_exc_q, if_exc_d;
    logic [4:0]   if_exccode_q, if_exccode_d;
    logic         redirect;
    logic         fetch_acc;

    // Checking the next PC lets im_req_o come straight from a flop.
    pc_addr_check u_addr_check (
        .pc_i      (pc_d),
        .im_base_i (IM_BASE),
        .im_top_i  (IM_TOP),
        .adel_o    (adel_d)
    );

    assign redirect  = exc_req_i | eret_i;
    assign fetch_acc = (state_q == ST_WAIT) && im_rvalid_i && !drop_q && !redirect;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if_exc_d     = if_exc_q;
        if_exccode_d = if_exccode_q;

        case (state_q)
            ST_REQ: begin
                if (adel_q) begin
                    if_valid_d   = 1'b1;
                    if_pc_d      = pc_q;
                    if_instr_d   = NOP;
                    if_exc_d     = 1'b1;
                    if_exccode_d = EXC_ADEL;
                    state_d      = ST_HOLD;
                end else if (req_q && im_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (im_rvalid_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        if_valid_d   = 1'b1;
                        if_pc_d      = pc_q;
                        if_instr_d   = im_rdata_i;
                        if_exc_d     = 1'b0;
                        if_exccode_d = 5'd0;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    pc_d       = next_pc_i;
                    if_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // With drop already pending only the PC moves; the stale response still drains.
        if (redirect) begin
            pc_d = exc_req_i ? EXC_VECTOR : epc_i;
            if (!drop_q) begin
                if_valid_d   = 1'b0;
                if_exc_d     = 1'b0;
                if_exccode_d = 5'd0;
                case (state_q)
                    ST_WAIT: begin
                        if (im_rvalid_i) begin
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_WAIT;
                            drop_d  = 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (req_q && im_gnt_i && !adel_q) begin
                            state_d = ST_WAIT;
                            drop_d  = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                    default: state_d = ST_REQ;
                endcase
            end
        end

        req_d = (state_d == ST_REQ) && !adel_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            adel_q       <= 1'b0;
            drop_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= NOP;
            if_exc_q     <= 1'b0;
            if_exccode_q <= 5'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            adel_q       <= adel_d;
            drop_q       <= drop_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_exc_q     <= if_exc_d;
            if_exccode_q <= if_exccode_d;
        end
    end

    assign pc_o         = pc_q;
    assign im_req_o     = req_q;
    assign im_addr_o    = pc_q;
    assign if_valid_o   = if_valid_q;
    assign if_pc_o      = if_pc_q;
    assign if_instr_o   = if_instr_q;
    assign if_exc_o     = if_exc_q;
    assign if_exccode_o = if_exccode_q;

`ifdef PC_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_acc};
        stall_cnt_d = stall_cnt_q + {31'd0, (state_q == ST_HOLD) && stall_i};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`else
    logic unused_fetch_acc;
    assign unused_fetch_acc = fetch_acc;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit with table vectors and a scoreboard
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc_i;
    logic        stall_i;
    logic        exc_req_i;
    logic        eret_i;
    logic [31:0] epc_i;
    logic [31:0] pc_o;
    logic        im_req_o;
    logic [31:0] im_addr_o;
    logic        im_gnt_i;
    logic        im_rvalid_i;
    logic [31:0] im_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_exc_o;
    logic [4:0]  if_exccode_o;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    pc_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .next_pc_i    (next_pc_i),
        .stall_i      (stall_i),
        .exc_req_i    (exc_req_i),
        .eret_i       (eret_i),
        .epc_i        (epc_i),
        .pc_o         (pc_o),
        .im_req_o     (im_req_o),
        .im_addr_o    (im_addr_o),
        .im_gnt_i     (im_gnt_i),
        .im_rvalid_i  (im_rvalid_i),
        .im_rdata_i   (im_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_instr_o   (if_instr_o),
        .if_exc_o     (if_exc_o),
        .if_exccode_o (if_exccode_o)
`ifdef PC_FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] npc;
        int          gdly;
        int          rdly;
        int          stall;
        bit          exc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          exc;
    } exp_t;

    localparam logic [31:0] DKEY = 32'hC0DE_0000;

    vec_t        vecs [8];
    exp_t        sb [$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    int          exp_fetch = 0;
    int          exp_stall = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_held;
        chk("if_valid", {31'd0, if_valid_o}, 32'd1);
        chk("if_pc", if_pc_o, cur.pc);
        chk("if_instr", if_instr_o, cur.exc ? 32'h0 : cur.instr);
        chk("if_exc", {31'd0, if_exc_o}, {31'd0, cur.exc});
        chk("if_exccode", {27'd0, if_exccode_o}, cur.exc ? 32'd4 : 32'd0);
    endtask

    task automatic pop_cmp;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            cur = sb.pop_front();
            cmp_held();
        end
    endtask

    task automatic wait_req;
        int n = 0;
        while (!im_req_o && n < 20) begin
            chk("valid_before_req", {31'd0, if_valid_o}, 32'd0);
            step();
            n++;
        end
        chk("req_seen", {31'd0, im_req_o}, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int gdly, input int rdly);
        wait_req();
        chk("im_addr", im_addr_o, addr);
        chk("pc_o", pc_o, addr);
        repeat (gdly) begin
            step();
            chk("req_hold", {31'd0, im_req_o}, 32'd1);
            chk("addr_hold", im_addr_o, addr);
        end
        im_gnt_i = 1'b1;
        step();
        im_gnt_i = 1'b0;
        chk("req_in_wait", {31'd0, im_req_o}, 32'd0);
        chk("valid_in_wait", {31'd0, if_valid_o}, 32'd0);
        repeat (rdly) step();
        im_rvalid_i = 1'b1;
        im_rdata_i  = data;
        sb.push_back('{pc: addr, instr: data, exc: 1'b0});
        step();
        im_rvalid_i = 1'b0;
        im_rdata_i  = 32'hBAD0_BAD0;
        exp_fetch++;
        pop_cmp();
    endtask

    task automatic consume(input logic [31:0] npc, input int n);
        repeat (n) begin
            step();
            cmp_held();
        end
        exp_stall += n;
        stall_i   = 1'b0;
        next_pc_i = npc;
        step();
        stall_i   = 1'b1;
        next_pc_i = 32'h0;
        chk("consumed_valid", {31'd0, if_valid_o}, 32'd0);
        chk("pc_update", pc_o, npc);
    endtask

    task automatic expect_exc(input logic [31:0] addr);
        int n = 0;
        sb.push_back('{pc: addr, instr: 32'h0, exc: 1'b1});
        while (!if_valid_o && n < 4) begin
            chk("no_req_adel", {31'd0, im_req_o}, 32'd0);
            step();
            n++;
        end
        chk("no_req_adel", {31'd0, im_req_o}, 32'd0);
        pop_cmp();
    endtask

    // Exception entry while the response is outstanding; the late rvalid must not land.
    task automatic do_dropped(input logic [31:0] addr);
        consume(addr, 0);
        wait_req();
        chk("drop_addr", im_addr_o, addr);
        im_gnt_i = 1'b1;
        step();
        im_gnt_i  = 1'b0;
        exc_req_i = 1'b1;
        step();
        exc_req_i = 1'b0;
        chk("exc_pc", pc_o, 32'h0000_4180);
        chk("exc_valid", {31'd0, if_valid_o}, 32'd0);
        chk("exc_noreq", {31'd0, im_req_o}, 32'd0);
        step();
        im_rvalid_i = 1'b1;
        im_rdata_i  = 32'hDEAD_BEEF;
        step();
        im_rvalid_i = 1'b0;
        chk("drop_valid", {31'd0, if_valid_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{npc: 32'h0000_3010, gdly: 0, rdly: 0, stall: 5, exc: 1'b0};
        vecs[1] = '{npc: 32'h0000_3014, gdly: 2, rdly: 1, stall: 0, exc: 1'b0};
        vecs[2] = '{npc: 32'h0000_3002, gdly: 0, rdly: 0, stall: 1, exc: 1'b1};
        vecs[3] = '{npc: 32'h0000_3018, gdly: 1, rdly: 3, stall: 0, exc: 1'b0};
        vecs[4] = '{npc: 32'h0000_7000, gdly: 0, rdly: 0, stall: 2, exc: 1'b1};
        vecs[5] = '{npc: 32'h0000_6FFC, gdly: 0, rdly: 2, stall: 0, exc: 1'b0};
        vecs[6] = '{npc: 32'h0000_2FFC, gdly: 0, rdly: 0, stall: 0, exc: 1'b1};
        vecs[7] = '{npc: 32'h0000_3000, gdly: 3, rdly: 0, stall: 1, exc: 1'b0};

        reset       = 1'b0;
        next_pc_i   = 32'h0;
        stall_i     = 1'b1;
        exc_req_i   = 1'b0;
        eret_i      = 1'b0;
        epc_i       = 32'h0;
        im_gnt_i    = 1'b0;
        im_rvalid_i = 1'b0;
        im_rdata_i  = 32'h0;
        repeat (3) step();
        chk("rst_pc", pc_o, 32'h0000_3000);
        chk("rst_req", {31'd0, im_req_o}, 32'd0);
        chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rst_instr", if_instr_o, 32'h0);
        chk("rst_exc", {31'd0, if_exc_o}, 32'd0);
        chk("rst_exccode", {27'd0, if_exccode_o}, 32'd0);
`ifdef PC_FETCH_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt_o, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt_o, 32'd0);
`endif
        reset = 1'b1;
        step();

        do_fetch(32'h0000_3000, 32'h0000_3000 ^ DKEY, 0, 0);

        for (int i = 0; i < 8; i++) begin
            consume(vecs[i].npc, vecs[i].stall);
            if (vecs[i].exc)
                expect_exc(vecs[i].npc);
            else
                do_fetch(vecs[i].npc, vecs[i].npc ^ DKEY, vecs[i].gdly, vecs[i].rdly);
        end

        do_dropped(32'h0000_3020);
        do_fetch(32'h0000_4180, 32'h0000_4180 ^ DKEY, 0, 1);

        // exc and eret together from HOLD, then eret alone while still requesting
        stall_i   = 1'b0;
        epc_i     = 32'h0000_3100;
        exc_req_i = 1'b1;
        eret_i    = 1'b1;
        step();
        exc_req_i = 1'b0;
        eret_i    = 1'b0;
        stall_i   = 1'b1;
        chk("both_redirect_pc", pc_o, 32'h0000_4180);
        chk("both_redirect_valid", {31'd0, if_valid_o}, 32'd0);
        eret_i = 1'b1;
        step();
        eret_i = 1'b0;
        chk("eret_pc", pc_o, 32'h0000_3100);
        do_fetch(32'h0000_3100, 32'h0000_3100 ^ DKEY, 0, 0);

        // redirect coinciding with gnt: the granted read must be drained and discarded
        consume(32'h0000_3030, 0);
        wait_req();
        im_gnt_i = 1'b1;
        eret_i   = 1'b1;
        epc_i    = 32'h0000_3200;
        step();
        im_gnt_i = 1'b0;
        eret_i   = 1'b0;
        chk("gnt_redirect_pc", pc_o, 32'h0000_3200);
        chk("gnt_redirect_noreq", {31'd0, im_req_o}, 32'd0);
        step();
        im_rvalid_i = 1'b1;
        im_rdata_i  = 32'hFEED_F00D;
        step();
        im_rvalid_i = 1'b0;
        chk("gnt_drop_valid", {31'd0, if_valid_o}, 32'd0);
        do_fetch(32'h0000_3200, 32'h0000_3200 ^ DKEY, 0, 0);

        // reset mid-transaction, with a response arriving right after release
        consume(32'h0000_3040, 0);
        wait_req();
        im_gnt_i = 1'b1;
        step();
        im_gnt_i = 1'b0;
        reset    = 1'b0;
        #1;
        chk("midrst_pc", pc_o, 32'h0000_3000);
        chk("midrst_req", {31'd0, im_req_o}, 32'd0);
        chk("midrst_valid", {31'd0, if_valid_o}, 32'd0);
        step();
        reset       = 1'b1;
        im_rvalid_i = 1'b1;
        im_rdata_i  = 32'h1234_5678;
        exp_fetch   = 0;
        exp_stall   = 0;
        step();
        im_rvalid_i = 1'b0;
        chk("midrst_ignore", {31'd0, if_valid_o}, 32'd0);
        do_fetch(32'h0000_3000, 32'h0000_3000 ^ DKEY, 0, 0);

        consume(32'h0000_3050, 4);
        do_fetch(32'h0000_3050, 32'h0000_3050 ^ DKEY, 1, 0);
        do_dropped(32'h0000_3060);
`ifdef PC_FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt_o, exp_fetch);
        chk("perf_stall", perf_stall_cnt_o, exp_stall);
        chk("perf_fetch_abs", perf_fetch_cnt_o, 32'd2);
        chk("perf_stall_abs", perf_stall_cnt_o, 32'd4);
`endif
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
